// File: rtl/gpu_command_intake.sv
// Command-word FIFO feeding a control unit that consumes 3-word shape commands.
// Define GPU_INTAKE_STATUS_EN to build the sticky overflow/underflow/proto_err flags.
module gpu_command_intake #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy,
    input  logic                       read,
    input  logic                       busy_reset,
    output logic [WIDTH-1:0]           op_data,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       proto_err,
    input  logic                       err_clear,
    output logic                       state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        ST_WAIT   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [1:0]       pop_cnt;

    logic pop_ok, rd_ok, end_shape, push_ok;
    logic ovf_evt, unf_evt, proto_evt;

    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign count     = cnt;
    assign busy      = (state == ST_ACTIVE);
    assign state_dbg = state;
    assign op_data   = empty ? '0 : mem[rd_ptr];

    // Strobes are single-cycle requests with no back-pressure: wr_en pushes when
    // space exists (or a pop frees it), read pops an operand only while busy and
    // fewer than two were taken, busy_reset pops operand 3 and ends the shape.
    always_comb begin
        pop_ok    = 1'b0;
        rd_ok     = 1'b0;
        end_shape = 1'b0;
        proto_evt = 1'b0;
        unf_evt   = (read || busy_reset) && empty;
        if (busy_reset) begin
            if (state != ST_ACTIVE) begin
                proto_evt = 1'b1;
            end else begin
                end_shape = 1'b1;
                pop_ok    = !empty;
                proto_evt = read || (pop_cnt != 2'd2);
            end
        end else if (read) begin
            if (state != ST_ACTIVE || pop_cnt == 2'd2) begin
                proto_evt = 1'b1;
            end else begin
                rd_ok  = 1'b1;
                pop_ok = !empty;
            end
        end
        push_ok = wr_en && (!full || pop_ok);
        ovf_evt = wr_en && !push_ok;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            pop_cnt <= '0;
            state   <= ST_WAIT;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
            case (state)
                ST_WAIT: begin
                    if (cnt >= CW'(3)) begin
                        state   <= ST_ACTIVE;
                        pop_cnt <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (end_shape) begin
                        state <= ST_WAIT;
                    end else if (rd_ok) begin
                        pop_cnt <= pop_cnt + 2'd1;
                    end
                end
                default: state <= ST_WAIT;
            endcase
        end
    end

`ifdef GPU_INTAKE_STATUS_EN
    // A fresh error event in the same cycle as err_clear keeps its flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            overflow  <= ovf_evt   || (overflow  && !err_clear);
            underflow <= unf_evt   || (underflow && !err_clear);
            proto_err <= proto_evt || (proto_err && !err_clear);
        end
    end
`else
    logic unused_status;
    assign unused_status = ^{err_clear, ovf_evt, unf_evt, proto_evt};
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
    assign proto_err = 1'b0;
`endif

endmodule
